// File: rtl/sevenseg_scan_ctrl_if.sv
// Load handshake between a numeric producer and the seven-segment scan controller.
// The producer drives a whole BCD frame and holds it until load_ready accepts it.
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load_valid;
    logic                    load_ready;
    logic [4*NUM_DIGITS-1:0] load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with a double-buffered BCD frame.
// Each digit gets a guard blank and then an on-time; loads swap in only at frame boundaries.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    sevenseg_scan_ctrl_if.slave   load,
    input  logic                  lzs_en,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_tick
);

    localparam int FRAME_W = 4 * NUM_DIGITS;
    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [CNT_W-1:0]     phase, phase_n;
    logic                 started;
    logic                 tick_n;
    logic [FRAME_W-1:0]   active, active_n;
    logic [FRAME_W-1:0]   shadow;
    logic                 shadow_full;
    logic [6:0]           seg_n;
    logic [NUM_DIGITS-1:0] dig_en_n;

    function automatic logic [6:0] decode(input logic [3:0] nibble);
        logic [6:0] s;
        case (nibble)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // A digit above 0 goes dark when it and every more significant nibble are zero.
    function automatic logic [6:0] digit_seg(input logic [FRAME_W-1:0] frame,
                                             input logic [IDX_W-1:0]   i,
                                             input logic               lzs);
        logic all_zero;
        all_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(i) && frame[4*k +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
        end
        if (lzs && i != '0 && all_zero) begin
            return 7'b1111111;
        end
        return decode(frame[4*int'(i) +: 4]);
    endfunction

    always_comb begin
        state_n = state;
        idx_n   = idx;
        phase_n = phase + CNT_W'(1);
        tick_n  = 1'b0;
        if (!started) begin
            state_n = BLANK;
            idx_n   = '0;
            phase_n = '0;
            tick_n  = 1'b1;
        end else if (state == BLANK) begin
            if (phase == BLANK_LAST) begin
                state_n = SHOW;
                phase_n = '0;
            end
        end else if (phase == DIGIT_LAST) begin
            state_n = BLANK;
            phase_n = '0;
            if (idx == IDX_LAST) begin
                idx_n  = '0;
                tick_n = 1'b1;
            end else begin
                idx_n = idx + IDX_W'(1);
            end
        end
    end

    // Outputs are computed from the next state so they land on the same edge as it.
    always_comb begin
        active_n = (frame_tick && shadow_full) ? shadow : active;
        seg_n    = 7'b1111111;
        dig_en_n = '0;
        if (state_n == SHOW) begin
            seg_n    = digit_seg(active_n, idx_n, lzs_en);
            dig_en_n = NUM_DIGITS'(1) << idx_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BLANK;
            idx        <= '0;
            phase      <= '0;
            started    <= 1'b0;
            frame_tick <= 1'b0;
            seg        <= 7'b1111111;
            dig_en     <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            phase      <= phase_n;
            started    <= 1'b1;
            frame_tick <= tick_n;
            seg        <= seg_n;
            dig_en     <= dig_en_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active      <= '1;
            shadow      <= '0;
            shadow_full <= 1'b0;
        end else begin
            active <= active_n;
            if (frame_tick && shadow_full) begin
                shadow_full <= 1'b0;
            end else if (load.load_valid && !shadow_full) begin
                shadow      <= load.load_data;
                shadow_full <= 1'b1;
            end
        end
    end

    assign load.load_ready = !shadow_full;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Scoreboard bench for sevenseg_scan_ctrl with a 4-digit, 24-cycle frame.
// Expected digit images are queued when a frame is loaded and popped as each digit is shown.
module tb_sevenseg_scan_ctrl;

    localparam int ND = 4;
    localparam int DC = 4;
    localparam int BC = 2;
    localparam int SLOT = DC + BC;
    localparam int FRAME = ND * SLOT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          lzs_en = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] dig_en;
    logic          frame_tick;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) load_bus ();

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .DIGIT_CYCLES(DC),
        .BLANK_CYCLES(BC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load_bus),
        .lzs_en    (lzs_en),
        .seg       (seg),
        .dig_en    (dig_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ND-1:0] dig;
        logic [6:0]    seg;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   pos = 0;

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [6:0] decodeDigit(input logic [3:0] n);
        logic [6:0] table_seg [16];
        table_seg = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                      7'b0000000, 7'b0000100, 7'b1111111, 7'b1111111,
                      7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
        return table_seg[n];
    endfunction

    function automatic logic [6:0] expectSeg(input logic [15:0] f, input int d, input logic lzs);
        bit upper_zero;
        upper_zero = 1'b1;
        for (int k = d; k < ND; k++) begin
            if (f[4*k +: 4] != 4'h0) upper_zero = 1'b0;
        end
        if (lzs && d > 0 && upper_zero) return 7'b1111111;
        return decodeDigit(f[4*d +: 4]);
    endfunction

    task automatic pushFrame(input logic [15:0] f);
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            e.dig = ND'(1 << d);
            e.seg = expectSeg(f, d, lzs_en);
            sb.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (frame_tick) pos = 0;
        else pos++;
    endtask

    task automatic advanceTo(input int target);
        int n;
        n = 0;
        while (pos != target && n < 60) begin
            step();
            n++;
        end
        if (pos != target) checkOutput("advance_timeout", 16'(pos), 16'(target));
    endtask

    task automatic applyStimulus(input logic [15:0] data, input bit push, output int waited);
        load_bus.load_valid = 1'b1;
        load_bus.load_data  = data;
        waited = 0;
        while (!load_bus.load_ready && waited < 100) begin
            step();
            waited++;
        end
        checkOutput("load_accept", load_bus.load_ready, 1'b1);
        step();
        load_bus.load_valid = 1'b0;
        checkOutput("ready_drop_after_load", load_bus.load_ready, 1'b0);
        if (push) pushFrame(data);
    endtask

    task automatic checkFrame(input bit wait_tick, input bit pending, input string tag);
        int   n;
        bit   leak;
        exp_t e;
        if (wait_tick) begin
            n = 0;
            leak = 1'b0;
            do begin
                step();
                n++;
                if (!frame_tick && pending && load_bus.load_ready) leak = 1'b1;
            end while (!frame_tick && n < 100);
            checkOutput($sformatf("%s_tick", tag), frame_tick, 1'b1);
            if (pending) checkOutput($sformatf("%s_ready_held_low", tag), leak, 1'b0);
            checkOutput($sformatf("%s_ready_at_tick", tag), load_bus.load_ready, !pending);
            step();
            checkOutput($sformatf("%s_ready_after_tick", tag), load_bus.load_ready, 1'b1);
            checkOutput($sformatf("%s_tick_one_cycle", tag), frame_tick, 1'b0);
        end
        for (int d = 0; d < ND; d++) begin
            if (pos <= SLOT*d + 1) begin
                advanceTo(SLOT*d + 1);
                checkOutput($sformatf("%s_blank%0d_dig", tag, d), dig_en, '0);
                checkOutput($sformatf("%s_blank%0d_seg", tag, d), seg, 7'h7F);
            end
            advanceTo(SLOT*d + BC + 1);
            if (sb.size() == 0) begin
                checkOutput($sformatf("%s_sb_empty", tag), 1'b1, 1'b0);
            end else begin
                e = sb.pop_front();
                checkOutput($sformatf("%s_d%0d_dig", tag, d), dig_en, e.dig);
                checkOutput($sformatf("%s_d%0d_seg", tag, d), seg, e.seg);
            end
        end
    endtask

    initial begin
        int waited;
        int kk;
        logic [ND-1:0] exp_dig;
        int n;

        load_bus.load_valid = 1'b0;
        load_bus.load_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_seg", seg, 7'h7F);
        checkOutput("reset_dig", dig_en, '0);
        checkOutput("reset_ready", load_bus.load_ready, 1'b1);
        checkOutput("reset_tick", frame_tick, 1'b0);

        rst = 1'b0;
        for (int k = 0; k <= FRAME; k++) begin
            step();
            kk = k % FRAME;
            exp_dig = ((kk % SLOT) < BC) ? '0 : ND'(1 << (kk / SLOT));
            checkOutput($sformatf("t1_tick_c%0d", k), frame_tick, (kk == 0));
            checkOutput($sformatf("t1_dig_c%0d", k), dig_en, exp_dig);
            checkOutput($sformatf("t1_seg_c%0d", k), seg, 7'h7F);
            checkOutput($sformatf("t1_ready_c%0d", k), load_bus.load_ready, 1'b1);
        end

        advanceTo(8);
        applyStimulus(16'h1234, 1'b1, waited);
        checkFrame(1'b1, 1'b1, "t2");

        lzs_en = 1'b1;
        applyStimulus(16'h0070, 1'b1, waited);
        checkFrame(1'b1, 1'b1, "t3a");
        applyStimulus(16'h0000, 1'b1, waited);
        checkFrame(1'b1, 1'b1, "t3b");
        lzs_en = 1'b0;
        applyStimulus(16'h0070, 1'b1, waited);
        checkFrame(1'b1, 1'b1, "t3c");

        applyStimulus(16'hA9F0, 1'b1, waited);
        checkFrame(1'b1, 1'b1, "t4");

        applyStimulus(16'h1111, 1'b1, waited);
        applyStimulus(16'h2222, 1'b1, waited);
        checkOutput("t5_stalled", 16'(waited > 0), 16'd1);
        checkOutput("t5_accept_pos", 16'(pos), 16'd2);
        checkFrame(1'b0, 1'b0, "t5a");
        checkFrame(1'b1, 1'b1, "t5b");

        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 100);
        checkOutput("t6_tick", frame_tick, 1'b1);
        pushFrame(16'h2222);
        applyStimulus(16'h4321, 1'b1, waited);
        checkOutput("t6_load_in_tick", 16'(waited), 16'd0);
        checkFrame(1'b0, 1'b0, "t6a");
        checkFrame(1'b1, 1'b1, "t6b");

        n = 0;
        do begin
            step();
            n++;
        end while (!frame_tick && n < 100);
        checkOutput("t6r_tick", frame_tick, 1'b1);
        step();
        applyStimulus(16'h8888, 1'b0, waited);
        advanceTo(2*SLOT + BC);
        checkOutput("t6r_pre_dig", dig_en, 4'b0100);
        checkOutput("t6r_pre_seg", seg, decodeDigit(4'h3));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6r_rst_seg", seg, 7'h7F);
        checkOutput("t6r_rst_dig", dig_en, '0);
        checkOutput("t6r_rst_ready", load_bus.load_ready, 1'b1);
        checkOutput("t6r_rst_tick", frame_tick, 1'b0);
        rst = 1'b0;
        pushFrame(16'hFFFF);
        checkFrame(1'b1, 1'b0, "t6r");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
